// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetches into a DEPTH-entry queue and squashes them on redirect.
// Optional IFU_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifu_prefetch #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instrom_ren,
    output logic [XLEN-1:0] instrom_addr,
    input  logic            instrom_gnt,
    input  logic            instrom_rvalid,
    input  logic [XLEN-1:0] instrom_rdata,
    input  logic            ex_if_redirect_wen,
    input  logic [XLEN-1:0] ex_if_redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc,
    input  logic            id_if_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic            started_q, started_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   live_q, live_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic [SW-1:0]   occupancy_s;
    logic [SW-1:0]   outstanding_s;
    logic            ren_s;
    logic            fire_s;
    logic            resp_ok_s;
    logic            discard_s;
    logic            deliver_s;
    logic            head_valid_s;
    logic            byp_s;
    logic            out_valid_s;
    logic            pop_s;
    logic            push_s;
    logic [XLEN-1:0] out_inst_s;
    logic [XLEN-1:0] out_pc_s;

    // Request issue, response classification and decode-side handshake
    always_comb begin
        occupancy_s   = {1'b0, count_q} + {1'b0, live_q};
        outstanding_s = {1'b0, live_q} + {1'b0, drop_q};
        // started_q is cleared by reset, so it stands in for rst and also delays issue to the first edge
        ren_s         = started_q && !ex_if_redirect_wen &&
                        (occupancy_s < SW'(DEPTH)) && (outstanding_s < SW'(DEPTH));
        fire_s        = ren_s && instrom_gnt;
        resp_ok_s     = instrom_rvalid && (outstanding_s != SW'(0));
        discard_s     = resp_ok_s && (drop_q != CW'(0));
        deliver_s     = resp_ok_s && (drop_q == CW'(0));
        head_valid_s  = (count_q != CW'(0));
`ifdef IFU_BYPASS_EN
        byp_s         = deliver_s && !head_valid_s;
`else
        byp_s         = 1'b0;
`endif
        out_valid_s   = (head_valid_s || byp_s) && !ex_if_redirect_wen;
        if (head_valid_s) begin
            out_inst_s = inst_mem_q[rd_ptr_q];
            out_pc_s   = pc_mem_q[rd_ptr_q];
        end else if (byp_s) begin
            out_inst_s = instrom_rdata;
            out_pc_s   = resp_pc_q;
        end else begin
            out_inst_s = inst_mem_q[rd_ptr_q];
            out_pc_s   = pc_mem_q[rd_ptr_q];
        end
        pop_s         = out_valid_s && id_if_ready && head_valid_s;
        push_s        = deliver_s && !ex_if_redirect_wen && !(byp_s && id_if_ready);
    end

    // Next-state for PCs, counters and queue pointers
    always_comb begin
        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        live_d     = live_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (ex_if_redirect_wen) begin
            // Everything still in flight becomes a drop; a response landing now is consumed here
            fetch_pc_d = ex_if_redirect_pc;
            resp_pc_d  = ex_if_redirect_pc;
            count_d    = CW'(0);
            live_d     = CW'(0);
            drop_d     = drop_q + live_q - CW'(resp_ok_s);
            wr_ptr_d   = PW'(0);
            rd_ptr_d   = PW'(0);
        end else begin
            if (fire_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (deliver_s) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            live_d  = live_q + CW'(fire_s) - CW'(deliver_s);
            drop_d  = drop_q - CW'(discard_s);
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= CW'(0);
            live_q     <= CW'(0);
            drop_q     <= CW'(0);
            wr_ptr_q   <= PW'(0);
            rd_ptr_q   <= PW'(0);
        end else begin
            started_q  <= started_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            inst_mem_q[wr_ptr_q] <= instrom_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign instrom_ren  = ren_s;
    assign instrom_addr = fetch_pc_q;
    assign if_id_valid  = out_valid_s;
    assign if_id_inst   = out_inst_s;
    assign if_id_pc     = out_pc_s;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: 1-cycle ROM model, in-order pop checker, redirect and reset scenarios.
// Latency expectations follow IFU_BYPASS_EN when the bench is built with it.
module tb_ifu_prefetch;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;
`ifdef IFU_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        instrom_ren;
    logic [31:0] instrom_addr;
    logic        instrom_gnt;
    logic        instrom_rvalid;
    logic [31:0] instrom_rdata;
    logic        ex_if_redirect_wen;
    logic [31:0] ex_if_redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        id_if_ready;

    int          n_checks;
    int          n_pass;
    int          pops;
    int          n_acc;
    int          p0;
    logic        rom_on;
    logic [31:0] exp_pc;
    logic [31:0] rom_q[$];

    ifu_prefetch dut (
        .clk                (clk),
        .rst                (rst),
        .instrom_ren        (instrom_ren),
        .instrom_addr       (instrom_addr),
        .instrom_gnt        (instrom_gnt),
        .instrom_rvalid     (instrom_rvalid),
        .instrom_rdata      (instrom_rdata),
        .ex_if_redirect_wen (ex_if_redirect_wen),
        .ex_if_redirect_pc  (ex_if_redirect_pc),
        .if_id_valid        (if_id_valid),
        .if_id_inst         (if_id_inst),
        .if_id_pc           (if_id_pc),
        .id_if_ready        (id_if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample grant and decode pop before the edge, then play the ROM after it
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = instrom_ren && instrom_gnt;
        a   = instrom_addr;
        if (if_id_valid && id_if_ready) begin
            check("pop_pc", if_id_pc, exp_pc);
            check("pop_inst", if_id_inst, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            rom_q.push_back(a);
            n_acc++;
        end
        if (rom_on && rom_q.size() > 0) begin
            instrom_rvalid = 1'b1;
            instrom_rdata  = rom_q.pop_front() ^ KEY;
        end else begin
            instrom_rvalid = 1'b0;
            instrom_rdata  = 32'd0;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; pops = 0; n_acc = 0; p0 = 0;
        rst = 1'b0; instrom_gnt = 1'b0; instrom_rvalid = 1'b0; instrom_rdata = 32'd0;
        ex_if_redirect_wen = 1'b0; ex_if_redirect_pc = 32'd0; id_if_ready = 1'b0;
        rom_on = 1'b1; exp_pc = 32'h8000_0000;
        tick(); tick();
        #1;
        check("rst_ren", {31'd0, instrom_ren}, 32'd0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_addr", instrom_addr, 32'h8000_0000);

        // Reset release, sequential fetch, decode always ready
        rst = 1'b1; instrom_gnt = 1'b1; id_if_ready = 1'b1;
        #1 check("ren_before_edge", {31'd0, instrom_ren}, 32'd0);
        tick();
        #1 check("ren_first", {31'd0, instrom_ren}, 32'd1);
        check("addr0", instrom_addr, 32'h8000_0000);
        tick();
        #1 check("addr1", instrom_addr, 32'h8000_0004);
        check("latency", {31'd0, if_id_valid}, {31'd0, BYP});
        tick();
        #1 check("addr2", instrom_addr, 32'h8000_0008);
        check("valid_up", {31'd0, if_id_valid}, 32'd1);
        check("first_pc", if_id_pc, BYP ? 32'h8000_0004 : 32'h8000_0000);
        repeat (4) tick();
        check("s1_pops", pops, BYP ? 32'd5 : 32'd4);

        // Fill with decode stalled, then drain one per cycle
        instrom_gnt = 1'b0;
        repeat (5) tick();
        #1 check("drained", {31'd0, if_id_valid}, 32'd0);
        id_if_ready = 1'b0; instrom_gnt = 1'b1; n_acc = 0;
        repeat (8) tick();
        #1 check("fill_acc", n_acc, 32'd4);
        check("full_ren", {31'd0, instrom_ren}, 32'd0);
        check("full_valid", {31'd0, if_id_valid}, 32'd1);
        check("hold_pc", if_id_pc, exp_pc);
        tick();
        #1 check("hold_pc2", if_id_pc, exp_pc);
        check("hold_inst2", if_id_inst, exp_pc ^ KEY);
        id_if_ready = 1'b1;
        #1 check("ren_full_pop", {31'd0, instrom_ren}, 32'd0);
        tick();
        #1 check("ren_resume", {31'd0, instrom_ren}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", {31'd0, if_id_valid}, 32'd1);
            tick();
        end

        // Redirect with two requests in flight
        instrom_gnt = 1'b0;
        repeat (5) tick();
        rom_on = 1'b0; instrom_gnt = 1'b1;
        tick(); tick();
        instrom_gnt = 1'b0;
        ex_if_redirect_wen = 1'b1; ex_if_redirect_pc = 32'h0000_1000;
        #1 check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_ren", {31'd0, instrom_ren}, 32'd0);
        tick();
        exp_pc = 32'h0000_1000; ex_if_redirect_wen = 1'b0; rom_on = 1'b1; instrom_gnt = 1'b1;
        #1 check("redir_addr", instrom_addr, 32'h0000_1000);
        tick();
        #1 check("stale1_hidden", {31'd0, if_id_valid}, 32'd0);
        tick();
        #1 check("stale2_hidden", {31'd0, if_id_valid}, 32'd0);
        p0 = pops;
        repeat (4) tick();
        check("redir_pops", {31'd0, pops > p0}, 32'd1);

        // Redirect coincident with a response and decode ready
        ex_if_redirect_wen = 1'b1; ex_if_redirect_pc = 32'h0000_2000;
        #1 check("coinc_valid", {31'd0, if_id_valid}, 32'd0);
        tick();
        exp_pc = 32'h0000_2000; ex_if_redirect_wen = 1'b0;
        #1 check("coinc_empty", {31'd0, if_id_valid}, 32'd0);
        check("coinc_addr", instrom_addr, 32'h0000_2000);
        check("coinc_ren", {31'd0, instrom_ren}, 32'd1);
        p0 = pops;
        repeat (4) tick();
        check("coinc_pops", {31'd0, pops > p0}, 32'd1);

        // Reset mid-burst, stray response, restart
        rst = 1'b0; rom_q.delete(); rom_on = 1'b0; instrom_rvalid = 1'b0;
        #1 check("mid_rst_ren", {31'd0, instrom_ren}, 32'd0);
        check("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("mid_rst_addr", instrom_addr, 32'h8000_0000);
        tick(); tick();
        rst = 1'b1; instrom_gnt = 1'b0;
        #1 check("rerst_ren", {31'd0, instrom_ren}, 32'd0);
        tick();
        instrom_rvalid = 1'b1; instrom_rdata = 32'hDEAD_BEEF;
        #1 check("stray_nobyp", {31'd0, if_id_valid}, 32'd0);
        tick();
        #1 check("stray_ignored", {31'd0, if_id_valid}, 32'd0);
        tick();
        #1 check("stray_ignored2", {31'd0, if_id_valid}, 32'd0);
        check("stray_addr", instrom_addr, 32'h8000_0000);
        exp_pc = 32'h8000_0000; rom_on = 1'b1; instrom_gnt = 1'b1;
        p0 = pops;
        repeat (6) tick();
        check("restart_pops", {31'd0, pops > p0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, >=2) and maximum outstanding requests.
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-004 SHALL have port clk  input  1  meaning the single clock; rising edge active.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-006 SHALL have port instrom_ren  output  1  meaning fetch request valid.
REQ-007 SHALL have port instrom_addr  output  XLEN  meaning fetch request address.
REQ-008 SHALL have port instrom_gnt  input  1  meaning request accepted this cycle.
REQ-009 SHALL have port instrom_rvalid  input  1  meaning in-order response valid.
REQ-010 SHALL have port instrom_rdata  input  XLEN  meaning response instruction.
REQ-011 SHALL have port ex_if_redirect_wen  input  1  meaning branch/jump redirect.
REQ-012 SHALL have port ex_if_redirect_pc  input  XLEN  meaning redirect target.
REQ-013 SHALL have port if_id_valid  output  1  meaning instruction available to decode.
REQ-014 SHALL have port if_id_inst  output  XLEN  meaning instruction to decode.
REQ-015 SHALL have port if_id_pc  output  XLEN  meaning PC of if_id_inst.
REQ-016 SHALL have port id_if_ready  input  1  meaning decode accepts this cycle.

Function
REQ-017 SHALL hold fetch_pc; instrom_addr = fetch_pc; fetch_pc += 4 (mod 2^XLEN) on instrom_ren && instrom_gnt.
REQ-018 SHALL track count (queue occupancy), live (accepted requests awaiting response) and drop (requests whose responses are discarded).
REQ-019 SHALL assert instrom_ren iff rst high, ex_if_redirect_wen low, count+live < DEPTH and live+drop < DEPTH.
REQ-020 SHALL on each instrom_rvalid: if drop>0 decrement drop and discard; else decrement live and deliver {rdata, resp_pc}, then resp_pc += 4.
REQ-021 SHALL write delivered responses into a circular FIFO; pointers wrap modulo DEPTH; a push while full SHALL never occur by REQ-019.
REQ-022 SHALL drive if_id_valid = (count != 0) && !ex_if_redirect_wen, presenting the head entry; pop on if_id_valid && id_if_ready.
REQ-023 SHALL permit simultaneous push and pop with count unchanged, including at count = DEPTH-1 and at count = 1.
REQ-024 SHALL on redirect edge: empty the queue, set drop <= drop + live (minus 1 if a response arrives that cycle), live <= 0, fetch_pc <= resp_pc <= ex_if_redirect_pc; any same-cycle response SHALL be discarded.
REQ-025 SHALL hold if_id_inst/if_id_pc stable while if_id_valid && !id_if_ready.
REQ-026 SHALL ignore instrom_rvalid when live+drop = 0 (protocol error, no state change).

Reset
REQ-027 SHALL, while rst low, asynchronously force fetch_pc = resp_pc = RESET_PC, count = live = drop = 0, pointers = 0, instrom_ren = 0, if_id_valid = 0.
REQ-028 SHALL, on rst low mid-operation, discard all outstanding requests; responses arriving after rst rises with live+drop = 0 follow REQ-026.
REQ-029 SHALL assert instrom_ren no earlier than the first rising clk edge after rst rises.

Configuration
REQ-030 SHALL, with macro IFU_BYPASS_EN defined, forward a delivered response combinationally to if_id_* when count = 0, not pushing it if id_if_ready is high that cycle (0-cycle fetch-to-decode latency).
REQ-031 SHALL, without IFU_BYPASS_EN, always push delivered responses; if_id_valid rises the cycle after instrom_rvalid (1-cycle latency).

Verification
REQ-032 SHALL cover reset release, gnt=1, 1-cycle ROM, ready=1 -> addresses 8000_0000, _0004, _0008 issued on consecutive cycles; if_id_pc follows in order.
REQ-033 SHALL cover ready=0 with DEPTH=4 -> exactly 4 requests accepted, instrom_ren deasserts, count=4; ready=1 -> one pop per cycle, fetching resumes.
REQ-034 SHALL cover redirect to 0000_1000 with 2 in flight -> both responses discarded, next if_id_pc = 0000_1000, no stale instruction presented.
REQ-035 SHALL cover redirect coincident with rvalid and a pop -> response dropped, queue empty, drop correct, if_id_valid low that cycle.
REQ-036 SHALL cover rst pulled low mid-burst -> all outputs at reset values immediately; restart fetch from 8000_0000.
REQ-037 SHALL cover both IFU_BYPASS_EN builds -> rvalid-to-if_id_valid latency of 0 and 1 cycles respectively on an empty queue.
